// File: rtl/seq_divider_pkg.sv
// Shared types and sizing helpers for the iterative restoring divider.
// State encodings, default width and iteration counter width.
package seq_divider_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit and try
// to subtract the divisor from the partial remainder.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   i_p,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH:0]   o_p,
  output logic             o_q
);

  logic [WIDTH:0] w_sh;
  logic [WIDTH:0] w_dx;

  assign w_sh = {i_p[WIDTH-1:0], i_bit};
  assign w_dx = {1'b0, i_d};

  // A set top bit means the shifted value already exceeds the divisor.
  assign o_q = i_p[WIDTH] | (w_sh >= w_dx);
  assign o_p = o_q ? (w_sh - w_dx) : w_sh;

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider: 2W-bit dividend by W-bit divisor,
// one quotient bit per clock behind a start/busy/done handshake.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_zero,
  output logic               overflow
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t r_state;
  state_t w_next;

  logic [WIDTH:0]   r_p;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dz;
  logic             r_ov;

  logic [WIDTH:0]   w_p_next;
  logic             w_qbit;
  logic             w_dz;
  logic             w_ov;
  logic             w_last;

  assign w_dz   = (divisor == '0);
  assign w_ov   = (dividend[2*WIDTH-1:WIDTH] >= divisor);
  assign w_last = (r_cnt == LAST);

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_p   (r_p),
    .i_bit (r_s[WIDTH-1]),
    .i_d   (r_d),
    .o_p   (w_p_next),
    .o_q   (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = (w_dz || w_ov) ? DONE : CALC;
      end
      CALC: begin
        if (w_last) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The final iteration writes straight into the result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p   <= '0;
      r_s   <= '0;
      r_d   <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_dz  <= 1'b0;
      r_ov  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_p   <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
            r_s   <= dividend[WIDTH-1:0];
            r_d   <= divisor;
            r_cnt <= '0;
            priority case (1'b1)
              w_dz: begin
                r_q  <= '1;
                r_r  <= '0;
                r_dz <= 1'b1;
                r_ov <= 1'b0;
              end
              w_ov: begin
                r_q  <= '1;
                r_r  <= '0;
                r_dz <= 1'b0;
                r_ov <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          r_p   <= w_p_next;
          r_s   <= {r_s[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_q  <= {r_s[WIDTH-2:0], w_qbit};
            r_r  <= w_p_next[WIDTH-1:0];
            r_dz <= 1'b0;
            r_ov <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state == CALC);
  assign done      = (r_state == DONE);
  assign quotient  = r_q;
  assign remainder = r_r;
  assign div_zero  = r_dz;
  assign overflow  = r_ov;

endmodule
